// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the cpu_ctrl control unit: FSM states,
// ISA opcode/op fields and datapath select codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_RD
    } ctrl_state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field meanings depend on the opcode: MOV uses 10/00, ALU uses all four
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RN   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/cpu_ctrl_ir_reg.sv
// 16-bit load-enable instruction register with asynchronous active-high clear.
module ir_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= 16'h0000;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Lab 6 RISC control unit: instruction register plus a Moore FSM that
// sequences register-file access, A/B/C/status loads and operand selects.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic [15:0] ir,
    output logic [2:0]  nsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic        write,
    output logic        w
);

    ctrl_state_t state, state_next;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic        is_movi, is_movr, is_mvn, is_cmp, is_alu3;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];

    assign is_movi = (opcode == OPC_MOV) && (op == OP_MOVI);
    assign is_movr = (opcode == OPC_MOV) && (op == OP_MOVR);
    assign is_mvn  = (opcode == OPC_ALU) && (op == OP_MVN);
    assign is_cmp  = (opcode == OPC_ALU) && (op == OP_CMP);
    assign is_alu3 = (opcode == OPC_ALU) && (op != OP_MVN);

    // IR only accepts a new word while idle, so it is stable during execution.
    ir_reg u_ir (
        .clk   (clk),
        .reset (reset),
        .en    (load && (state == S_WAIT)),
        .d     (in),
        .q     (ir)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_WAIT;
        else
            state <= state_next;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        nsel       = NSEL_NONE;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = VSEL_C;
        write      = 1'b0;
        w          = 1'b0;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_movi)
                    state_next = S_WRITE_IMM;
                else if (is_movr || is_mvn)
                    state_next = S_GET_B;
                else if (is_alu3)
                    state_next = S_GET_A;
                else
                    state_next = S_WAIT;
            end
            S_WRITE_IMM: begin
                nsel       = NSEL_RN;
                vsel       = VSEL_IMM8;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_GET_A: begin
                nsel       = NSEL_RN;
                loada      = 1'b1;
                state_next = S_GET_B;
            end
            S_GET_B: begin
                nsel       = NSEL_RM;
                loadb      = 1'b1;
                state_next = S_ALU;
            end
            S_ALU: begin
                asel = is_movr;
                if (is_cmp) begin
                    loads      = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    loadc      = 1'b1;
                    state_next = S_WRITE_RD;
                end
            end
            S_WRITE_RD: begin
                nsel       = NSEL_RD;
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            default: state_next = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl: walks each instruction class
// cycle by cycle and compares the packed control outputs and IR.
module tb_cpu_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic [15:0] ir;
    logic [2:0]  nsel;
    logic        loada, loadb, loadc, loads, asel, bsel, write, w;
    logic [1:0]  vsel;

    int errors = 0;
    int checks = 0;

    cpu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .load  (load),
        .s     (s),
        .ir    (ir),
        .nsel  (nsel),
        .loada (loada),
        .loadb (loadb),
        .loadc (loadc),
        .loads (loads),
        .asel  (asel),
        .bsel  (bsel),
        .vsel  (vsel),
        .write (write),
        .w     (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control word: {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write}
    localparam logic [12:0] E_IDLE    = 13'b1_000_0000_00_00_0;
    localparam logic [12:0] E_DECODE  = 13'b0_000_0000_00_00_0;
    localparam logic [12:0] E_WIMM    = 13'b0_100_0000_00_10_1;
    localparam logic [12:0] E_GETA    = 13'b0_100_1000_00_00_0;
    localparam logic [12:0] E_GETB    = 13'b0_001_0100_00_00_0;
    localparam logic [12:0] E_ALU_C   = 13'b0_000_0010_00_00_0;
    localparam logic [12:0] E_ALU_MOV = 13'b0_000_0010_10_00_0;
    localparam logic [12:0] E_ALU_CMP = 13'b0_000_0001_00_00_0;
    localparam logic [12:0] E_WRD     = 13'b0_010_0000_00_00_1;

    function automatic logic [12:0] ctl_word();
        return {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write};
    endfunction

    task automatic check_ctl(input string tag, input logic [12:0] expected);
        logic [12:0] observed;
        observed = ctl_word();
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_ir(input string tag, input logic [15:0] expected);
        checks++;
        assert (ir === expected) else begin
            errors++;
            $error("FAIL %s: observed ir=%h expected ir=%h", tag, ir, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] word);
        in   = word;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in    = 16'h0000;
        load  = 1'b0;
        s     = 1'b0;
        #1;
        check_ctl("reset_idle", E_IDLE);
        check_ir("reset_ir", 16'h0000);
        step();
        reset = 1'b0;

        // ADD aborted by reset while in GET_B
        load_ir(16'hA0A1);
        check_ir("add_load", 16'hA0A1);
        s = 1'b1; step(); s = 1'b0;
        check_ctl("abort_decode", E_DECODE);
        step(); check_ctl("abort_geta", E_GETA);
        step(); check_ctl("abort_getb", E_GETB);
        #2 reset = 1'b1;
        #1;
        check_ctl("abort_idle", E_IDLE);
        check_ir("abort_ir", 16'h0000);
        step();
        reset = 1'b0;
        check_ctl("abort_hold", E_IDLE);

        // MOV R1,#5
        load_ir(16'hD105);
        s = 1'b1; step(); s = 1'b0;
        check_ctl("movi_decode", E_DECODE);
        step(); check_ctl("movi_write", E_WIMM);
        step(); check_ctl("movi_done", E_IDLE);

        // ADD R5,R0,R1
        load_ir(16'hA0A1);
        s = 1'b1; step(); s = 1'b0;
        check_ctl("add_decode", E_DECODE);
        step(); check_ctl("add_geta", E_GETA);
        step(); check_ctl("add_getb", E_GETB);
        step(); check_ctl("add_alu", E_ALU_C);
        step(); check_ctl("add_wrd", E_WRD);
        step(); check_ctl("add_done", E_IDLE);

        // CMP R1,R1
        load_ir(16'hA901);
        s = 1'b1; step(); s = 1'b0;
        check_ctl("cmp_decode", E_DECODE);
        step(); check_ctl("cmp_geta", E_GETA);
        step(); check_ctl("cmp_getb", E_GETB);
        step(); check_ctl("cmp_alu", E_ALU_CMP);
        step(); check_ctl("cmp_done", E_IDLE);

        // MOV R7,R1 with a load pulse mid-execution
        load_ir(16'hC0E1);
        s = 1'b1; step(); s = 1'b0;
        check_ctl("movr_decode", E_DECODE);
        step(); check_ctl("movr_getb", E_GETB);
        in = 16'hFFFF; load = 1'b1;
        step(); check_ctl("movr_alu", E_ALU_MOV);
        check_ir("movr_ir_frozen_alu", 16'hC0E1);
        step(); check_ctl("movr_wrd", E_WRD);
        step(); check_ctl("movr_done", E_IDLE);
        load = 1'b0;
        check_ir("movr_ir_frozen", 16'hC0E1);

        // MVN R3,R2
        load_ir(16'hB862);
        s = 1'b1; step(); s = 1'b0;
        check_ctl("mvn_decode", E_DECODE);
        step(); check_ctl("mvn_getb", E_GETB);
        step(); check_ctl("mvn_alu", E_ALU_C);
        step(); check_ctl("mvn_wrd", E_WRD);
        step(); check_ctl("mvn_done", E_IDLE);

        // Illegal opcode returns after one edge
        load_ir(16'hE000);
        s = 1'b1; step(); s = 1'b0;
        check_ctl("ill_decode", E_DECODE);
        step(); check_ctl("ill_done", E_IDLE);
        check_ir("ill_ir", 16'hE000);

        // load and s together: the new word is decoded
        in = 16'hD205; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        check_ir("ls_ir", 16'hD205);
        check_ctl("ls_decode", E_DECODE);
        step(); check_ctl("ls_write", E_WIMM);
        step(); check_ctl("ls_done", E_IDLE);

        // s held high: one WAIT cycle between back-to-back instructions
        s = 1'b1;
        step(); check_ctl("hold_decode1", E_DECODE);
        step(); check_ctl("hold_write1", E_WIMM);
        step(); check_ctl("hold_wait", E_IDLE);
        step(); check_ctl("hold_decode2", E_DECODE);
        s = 1'b0;
        step(); check_ctl("hold_write2", E_WIMM);
        step(); check_ctl("hold_done", E_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Control unit for the Lab 6 simple RISC datapath. Holds the 16-bit instruction register and runs a Moore state machine that sequences register-file reads and writes, the A/B/C/status loads and the operand/writeback selects. The instruction register feeds the instruction decoder, and the `nsel` output drives the decoder's register-select mux. `w` high means the unit is idle and ready for the next instruction.

## Interface
Parameters:
- none (widths fixed by the ISA: 16-bit instruction, 3-bit register index)

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `in` in 16: instruction word from the switches / bus.
- `load` in 1: instruction-register load strobe.
- `s` in 1: start strobe.
- `ir` out 16: instruction register contents, to the decoder.
- `nsel` out 3: one-hot register select (001 Rm, 010 Rd, 100 Rn); 000 when no register access.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: datapath register enables.
- `asel` out 1: 1 forces ALU input A to 0.
- `bsel` out 1: 1 selects sximm5 for ALU input B; always 0 in this ISA subset.
- `vsel` out 2: writeback source (00 C, 01 PC = 0, 10 sximm8, 11 mdata).
- `write` out 1: register-file write enable.
- `w` out 1: idle/ready.

## Operation
- IR: if `load` is high while in WAIT, `ir <= in`. `load` is ignored in every other state, so IR is frozen during execution.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_RD.
- WAIT: `w=1`. If `s`, go to DECODE; otherwise stay.
- DECODE decodes opcode `ir[15:13]` and op `ir[12:11]`:
  - 110/10 (MOV Rn,#imm8) goes to WRITE_IMM.
  - 110/00 (MOV Rd,Rm) goes to GET_B.
  - 101/11 (MVN) goes to GET_B.
  - 101/00, 01, 10 (ADD, CMP, AND) go to GET_A.
  - Anything else is illegal and returns to WAIT with no side effects.
- WRITE_IMM: `nsel=100`, `vsel=10`, `write=1`. Next state WAIT.
- GET_A: `nsel=100`, `loada=1`. Next state GET_B.
- GET_B: `nsel=001`, `loadb=1`. Next state ALU.
- ALU:
  - CMP: `loads=1`, `loadc=0`, then WAIT.
  - Other instructions: `loadc=1`, then WRITE_RD.
  - `asel=1` for MOV Rd,Rm, 0 otherwise.
- WRITE_RD: `nsel=010`, `vsel=00`, `write=1`. Next state WAIT.
- All control outputs are pure functions of the state register and `ir`, so they are glitch-free at clock edges. Any output not listed for a state is 0.

## Timing
- Reset (asynchronous, immediate): state WAIT, `ir=16'h0000`, `w=1`, `nsel=000`, `vsel=00`, and all strobes plus `asel`/`bsel` at 0.
- Latency from the edge that samples `s` to the edge that returns to WAIT (`w` high again):
  - MOV imm: 2
  - MOV reg: 4
  - MVN: 4
  - CMP: 4
  - ADD/AND: 5
  - illegal: 1
- `load` and `s` both high in WAIT on the same edge: IR captures `in`, and DECODE on the next cycle decodes the new word.
- `s` held high continuously: after returning to WAIT, the next instruction starts on the following edge (one WAIT cycle minimum).
- `s` outside WAIT is ignored.
- `reset` asserted mid-instruction aborts it: no further strobes are issued, and IR clears.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state enum `ctrl_state_t`
  - opcode constants `OPC_MOV=3'b110`, `OPC_ALU=3'b101`
  - op constants (`OP_ADD`, `OP_CMP`, `OP_AND`, `OP_MVN`, `OP_MOVI`, `OP_MOVR`)
  - nsel constants `NSEL_RM`, `NSEL_RD`, `NSEL_RN`
  - vsel constants `VSEL_C`, `VSEL_PC`, `VSEL_IMM8`, `VSEL_MDATA`
- One natural sub-module: `ir_reg` (16-bit load-enable register with asynchronous reset).

## Test plan
- Reset mid-ADD (in the GET_B state): state returns to WAIT immediately, `ir=0`, `w=1`, all strobes 0.
- Load `16'hD105` (MOV R1,#5), then pulse `s`: DECODE, then WRITE_IMM with `nsel=100`, `vsel=10`, `write=1` for exactly one cycle; `w` high 2 edges after `s`.
- Load `16'hA0A1` (ADD R5,R0,R1): in order, `loada` with `nsel=100`, `loadb` with `nsel=001`, `loadc`, then `write` with `nsel=010`/`vsel=00`; `w` returns after 5 edges.
- Load `16'hA901` (CMP R1,R1): `loads=1` in ALU, never `loadc` or `write`; `w` returns after 4 edges.
- Load `16'hC0E1` (MOV R7,R1): GET_B, then ALU with `asel=1`, then WRITE_RD. Pulse `load` with a new word mid-execution: `ir` stays unchanged.
- Load `16'hE000` (illegal opcode) with `s`: back to WAIT after 1 edge, no strobes. Assert `load`+`s` together with `16'hD205`: executes MOV R2,#5.
